ir_sequencer: RTL and testbench

- Instruction-register and step sequencer that sits directly upstream of the combinational opcode decoder.
- Holds the current opcode (IR) and the M-cycle step counter, and feeds both to the decoder.
- Consumes the decoder's done / is_cond / next_cond strobes, evaluates branch conditions against the flags, and handles the opcodes the decoder has no microcode for: NOP, HALT, and illegal opcodes (lockup).
- One M-cycle per clock.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/ir_sequencer_cc_eval.sv | 24 ++
 rtl/ir_sequencer.sv | 146 ++++++++++++++
 tb/tb_ir_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state, branch condition codes and the
// opcodes the sequencer handles itself.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    LOCK = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    CC_NZ = 2'd0,
    CC_Z  = 2'd1,
    CC_NC = 2'd2,
    CC_C  = 2'd3
  } cc_t;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_HALT = 8'h76;

endpackage

// File: rtl/ir_sequencer_cc_eval.sv
// Branch condition evaluator (cc field against Z/C flags); shared with the
// JP/CALL/RET cc paths.
module cc_eval
  import cpu_pkg::*;
(
  input  logic [1:0] cc,
  input  logic       flag_z,
  input  logic       flag_c,
  output logic       cc_true
);

  // Select the flag polarity named by the condition code
  always_comb begin
    cc_true = 1'b0;
    case (cc_t'(cc))
      CC_NZ:   cc_true = ~flag_z;
      CC_Z:    cc_true = flag_z;
      CC_NC:   cc_true = ~flag_c;
      CC_C:    cc_true = flag_c;
      default: cc_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/ir_sequencer.sv
// Instruction register and M-cycle step sequencer feeding the opcode decoder.
// Optional retired-instruction counter enabled by macro SEQ_RETIRE_CNT_EN.
module ir_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_OPCODE = OP_NOP,
  parameter logic [7:0] HALT_OPCODE  = OP_HALT,
  parameter logic [2:0] STEP_LIMIT   = 3'd7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ir_in,
  input  logic        dec_done,
  input  logic        dec_is_cond,
  input  logic [2:0]  dec_next_cond,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        mem_wait,
  input  logic        irq_pending,
  output logic [7:0]  opcode,
  output logic [2:0]  step,
  output logic        dec_en,
  output logic        seq_fetch,
  output logic        halted,
  output logic        locked
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0] retired_cnt
`endif
);

  seq_state_t state_r;
  seq_state_t state_n_s;
  logic [7:0] opcode_r;
  logic [7:0] opcode_n_s;
  logic [2:0] step_r;
  logic [2:0] step_n_s;
  logic       latch_s;
  logic       cc_true_s;

  cc_eval u_cc_eval (
    .cc      (opcode_r[4:3]),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .cc_true (cc_true_s)
  );

  assign seq_fetch = ~mem_wait &
                     (((state_r == RUN) & (opcode_r == OP_NOP) & (step_r == 3'd0)) |
                      ((state_r == HALT) & irq_pending));
  assign dec_en    = ~mem_wait & (state_r == RUN) &
                     (opcode_r != OP_NOP) & (opcode_r != HALT_OPCODE);

  // Next IR/step/state; a stall holds everything
  always_comb begin
    state_n_s  = state_r;
    opcode_n_s = opcode_r;
    step_n_s   = step_r;
    latch_s    = 1'b0;
    if (mem_wait) begin
      latch_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (seq_fetch || (dec_en && dec_done)) begin
            // done outranks is_cond; HALT must be seen before any decoder strobe
            opcode_n_s = ir_in;
            step_n_s   = 3'd0;
            latch_s    = 1'b1;
            if (!seq_fetch && (opcode_r == HALT_OPCODE)) begin
              opcode_n_s = opcode_r;
              state_n_s  = HALT;
              latch_s    = 1'b0;
            end else begin
              state_n_s = RUN;
            end
          end else if (opcode_r == HALT_OPCODE) begin
            state_n_s = HALT;
            step_n_s  = 3'd0;
          end else if (dec_en && dec_is_cond) begin
            step_n_s = cc_true_s ? (step_r + 3'd1) : dec_next_cond;
          end else if (step_r == STEP_LIMIT) begin
            state_n_s = LOCK;
          end else begin
            step_n_s = step_r + 3'd1;
          end
        end
        HALT: begin
          if (irq_pending) begin
            opcode_n_s = ir_in;
            step_n_s   = 3'd0;
            state_n_s  = RUN;
            latch_s    = 1'b1;
          end else begin
            state_n_s = HALT;
          end
        end
        LOCK: begin
          state_n_s = LOCK;
        end
        default: begin
          state_n_s = LOCK;
        end
      endcase
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RUN;
      opcode_r <= RESET_OPCODE;
      step_r   <= 3'd0;
    end else begin
      state_r  <= state_n_s;
      opcode_r <= opcode_n_s;
      step_r   <= step_n_s;
    end
  end

  assign opcode = opcode_r;
  assign step   = step_r;
  assign halted = (state_r == HALT);
  assign locked = (state_r == LOCK);

`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retired_cnt_r;

  // Count every IR load; wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_r <= 16'd0;
    end else if (latch_s) begin
      retired_cnt_r <= retired_cnt_r + 16'd1;
    end else begin
      retired_cnt_r <= retired_cnt_r;
    end
  end

  assign retired_cnt = retired_cnt_r;
`else
  logic unused_latch_s;
  assign unused_latch_s = latch_s;
`endif

endmodule

// File: tb/tb_ir_sequencer.sv
// Directed scoreboard bench for ir_sequencer (optionally with SEQ_RETIRE_CNT_EN).
module tb_ir_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ir_in;
  logic        dec_done;
  logic        dec_is_cond;
  logic [2:0]  dec_next_cond;
  logic        flag_z;
  logic        flag_c;
  logic        mem_wait;
  logic        irq_pending;
  logic [7:0]  opcode;
  logic [2:0]  step;
  logic        dec_en;
  logic        seq_fetch;
  logic        halted;
  logic        locked;
`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retired_cnt;
`endif

  ir_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ir_in         (ir_in),
    .dec_done      (dec_done),
    .dec_is_cond   (dec_is_cond),
    .dec_next_cond (dec_next_cond),
    .flag_z        (flag_z),
    .flag_c        (flag_c),
    .mem_wait      (mem_wait),
    .irq_pending   (irq_pending),
    .opcode        (opcode),
    .step          (step),
    .dec_en        (dec_en),
    .seq_fetch     (seq_fetch),
    .halted        (halted),
    .locked        (locked)
`ifdef SEQ_RETIRE_CNT_EN
    ,
    .retired_cnt   (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ret_exp  = 0;

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ret();
`ifdef SEQ_RETIRE_CNT_EN
    push("retired_cnt", 16'(ret_exp));
    check(retired_cnt);
`endif
  endtask

  typedef struct {
    logic [7:0] op;
    logic       z;
    logic       c;
    logic [2:0] exp_step;
  } cc_vec_t;

  cc_vec_t cc_tab[4];

  initial begin
    cc_tab[0] = '{8'h28, 1'b1, 1'b0, 3'd1}; // Z taken
    cc_tab[1] = '{8'h28, 1'b0, 1'b0, 3'd5}; // Z not taken
    cc_tab[2] = '{8'h30, 1'b0, 1'b0, 3'd1}; // NC taken
    cc_tab[3] = '{8'h38, 1'b0, 1'b1, 3'd1}; // C taken
    rst_n = 1'b0; ir_in = 8'h3E; dec_done = 1'b0; dec_is_cond = 1'b0;
    dec_next_cond = 3'd0; flag_z = 1'b0; flag_c = 1'b0;
    mem_wait = 1'b0; irq_pending = 1'b0;
    #12;
    push("rst_opcode", 16'h00); check(16'(opcode));
    push("rst_step", 16'h0);    check(16'(step));
    push("rst_halted", 16'h0);  check(16'(halted));
    push("rst_locked", 16'h0);  check(16'(locked));
    check_ret();

    // First cycle out of reset is a sequencer fetch
    rst_n = 1'b1;
    #1;
    push("boot_fetch", 16'h1);  check(16'(seq_fetch));
    push("boot_dec_en", 16'h0); check(16'(dec_en));
    tick(); ret_exp++;
    push("boot_opcode", 16'h3E); check(16'(opcode));
    push("boot_step", 16'h0);    check(16'(step));
    push("boot_dec_en1", 16'h1); check(16'(dec_en));

    // JR NZ with Z set: condition fails, jump to next_cond
    dec_done = 1'b1; ir_in = 8'h20;
    tick(); ret_exp++;
    push("jr_opcode", 16'h20); check(16'(opcode));
    dec_done = 1'b0; dec_is_cond = 1'b1; dec_next_cond = 3'd3; flag_z = 1'b1;
    tick();
    push("jrnz_fail_step", 16'h3); check(16'(step));
    dec_is_cond = 1'b0; dec_done = 1'b1;
    tick(); ret_exp++;
    dec_done = 1'b0; dec_is_cond = 1'b1; flag_z = 1'b0;
    tick();
    push("jrnz_pass_step", 16'h1); check(16'(step));
    dec_is_cond = 1'b0;
    tick();
    push("jr_step2", 16'h2); check(16'(step));
    // done and is_cond together: done wins
    dec_done = 1'b1; dec_is_cond = 1'b1; ir_in = 8'h01;
    tick(); ret_exp++;
    push("done_opcode", 16'h01); check(16'(opcode));
    push("done_step", 16'h0);    check(16'(step));
    dec_is_cond = 1'b0;

    // HALT latched on done, halted the following cycle
    ir_in = 8'h76;
    tick(); ret_exp++;
    push("halt_latched", 16'h76); check(16'(opcode));
    push("halt_not_yet", 16'h0);  check(16'(halted));
    dec_done = 1'b1; ir_in = 8'h55;
    tick();
    push("halt_entered", 16'h1); check(16'(halted));
    push("halt_dec_en", 16'h0);  check(16'(dec_en));
    dec_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      push("halt_opcode", 16'h76); check(16'(opcode));
      push("halt_step", 16'h0);    check(16'(step));
      push("halt_held", 16'h1);    check(16'(halted));
    end
    check_ret();
    // Wake deferred while stalled
    irq_pending = 1'b1; mem_wait = 1'b1; ir_in = 8'h00;
    #1;
    push("wake_stall_fetch", 16'h0); check(16'(seq_fetch));
    tick();
    push("wake_stall_halted", 16'h1); check(16'(halted));
    mem_wait = 1'b0;
    #1;
    push("wake_fetch", 16'h1); check(16'(seq_fetch));
    tick(); ret_exp++;
    irq_pending = 1'b0;
    push("wake_halted", 16'h0); check(16'(halted));
    push("wake_opcode", 16'h00); check(16'(opcode));

    // Back-to-back NOP fetches, then opcode 01
    tick(); ret_exp++;
    tick(); ret_exp++;
    push("nop_opcode", 16'h00); check(16'(opcode));
    ir_in = 8'h01;
    tick(); ret_exp++;
    check_ret();
    tick();
    push("mw_step1", 16'h1); check(16'(step));

    // Memory stall freezes the step counter and masks strobes
    mem_wait = 1'b1; dec_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      push("mw_dec_en", 16'h0);    check(16'(dec_en));
      push("mw_seq_fetch", 16'h0); check(16'(seq_fetch));
      tick();
      push("mw_step_hold", 16'h1); check(16'(step));
    end
    check_ret();
    mem_wait = 1'b0; dec_done = 1'b0;
    tick();
    push("mw_release_step", 16'h2); check(16'(step));

    // Condition code table
    for (int i = 0; i < 4; i++) begin
      dec_done = 1'b1; ir_in = cc_tab[i].op;
      tick(); ret_exp++;
      dec_done = 1'b0; dec_is_cond = 1'b1; dec_next_cond = 3'd5;
      flag_z = cc_tab[i].z; flag_c = cc_tab[i].c;
      tick();
      push("cc_step", 16'(cc_tab[i].exp_step)); check(16'(step));
      dec_is_cond = 1'b0;
    end

    // Lockup when done never arrives
    dec_done = 1'b1; ir_in = 8'hD3;
    tick(); ret_exp++;
    dec_done = 1'b0;
    push("lk_step0", 16'h0); check(16'(step));
    for (int i = 1; i < 8; i++) begin
      tick();
      push("lk_step", 16'(i)); check(16'(step));
      push("lk_not_locked", 16'h0); check(16'(locked));
    end
    tick();
    push("lk_locked", 16'h1); check(16'(locked));
    push("lk_step7", 16'h7);  check(16'(step));
    dec_done = 1'b1; ir_in = 8'h00;
    tick(); tick();
    push("lk_hold_step", 16'h7);    check(16'(step));
    push("lk_hold_opcode", 16'hD3); check(16'(opcode));
    push("lk_dec_en", 16'h0);       check(16'(dec_en));
    push("lk_locked2", 16'h1);      check(16'(locked));
    check_ret();
    dec_done = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    push("lk_rst_opcode", 16'h00); check(16'(opcode));
    push("lk_rst_step", 16'h0);    check(16'(step));
    push("lk_rst_locked", 16'h0);  check(16'(locked));
    ret_exp = 0;
    check_ret();
    rst_n = 1'b1;

    // Asynchronous reset mid-instruction
    ir_in = 8'h3E;
    tick();
    tick(); tick();
    push("ar_pre_step", 16'h2); check(16'(step));
    #2 rst_n = 1'b0;
    #1;
    push("ar_opcode", 16'h00); check(16'(opcode));
    push("ar_step", 16'h0);    check(16'(step));
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
